// File: rtl/fu_cfg_seq.sv
// fu_cfg_seq: context-replay config sequencer for a PE FU cluster; define CFG_SEQ_HOLD_LAST_EN to hold the last context when idle
module fu_cfg_seq #(
  parameter int CONFIG_ALL = 64,
  parameter int IN_WIDTH = 16,
  parameter int NUM_CTX = 8,
  localparam int IW = $clog2(NUM_CTX)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid_i,
  input  logic [IN_WIDTH-1:0]   cfg_data_i,
  output logic                  cfg_ready_o,
  input  logic                  load_clr_i,
  input  logic                  start_i,
  input  logic [IW-1:0]         last_ctx_i,
  input  logic [7:0]            loops_i,
  input  logic                  halt_i,
  output logic [CONFIG_ALL-1:0] config_all_o,
  output logic [IW-1:0]         ctx_idx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [IW:0]           fill_o
);
  localparam int BEATS = CONFIG_ALL / IN_WIDTH;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [IW:0] FULL = (IW + 1)'(NUM_CTX);
`ifdef CFG_SEQ_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;
  logic [IW:0] fill_q, fill_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [IW-1:0] end_q, end_d, idx_q, idx_d, nxt_idx, idle_idx;
  logic [7:0] loop_q, loop_d;
  logic [CONFIG_ALL-1:0] cfg_q, cfg_d, idle_cfg;
  logic [CONFIG_ALL-1:0] mem_q [NUM_CTX];
  logic beat_we, at_end;
  assign cfg_ready_o = (state_q == IDLE) && (fill_q < FULL) && !load_clr_i;
  assign beat_we = cfg_valid_i && cfg_ready_o;
  assign at_end = idx_q == end_q;
  assign nxt_idx = at_end ? '0 : idx_q + IW'(1);
  assign idle_cfg = HOLD ? cfg_q : '0;
  assign idle_idx = HOLD ? idx_q : '0;
  // context storage: beats land LSB-first in the slot being filled
  always_ff @(posedge clk) begin
    if (beat_we) mem_q[fill_q[IW-1:0]][beat_q*IN_WIDTH +: IN_WIDTH] <= cfg_data_i;
  end
  // load bookkeeping and playback next-state
  always_comb begin
    state_d = state_q;
    fill_d = fill_q;
    beat_d = beat_q;
    end_d = end_q;
    loop_d = loop_q;
    cfg_d = cfg_q;
    idx_d = idx_q;
    if (beat_we) begin
      beat_d = beat_q == LAST_BEAT ? '0 : beat_q + BW'(1);
      fill_d = beat_q == LAST_BEAT ? fill_q + (IW + 1)'(1) : fill_q;
    end
    if (load_clr_i) begin
      fill_d = '0;
      beat_d = '0;
    end
    case (state_q)
      IDLE: begin
        cfg_d = idle_cfg;
        idx_d = idle_idx;
        if (start_i && fill_q != '0) begin
          state_d = RUN;
          beat_d = '0;
          end_d = ({1'b0, last_ctx_i} < fill_q) ? last_ctx_i : IW'(fill_q - (IW + 1)'(1));
          loop_d = loops_i;
          idx_d = '0;
          cfg_d = mem_q[IW'(0)];
        end
      end
      RUN: begin
        if (halt_i || (at_end && loop_q == '0)) begin
          state_d = DONE;
          cfg_d = idle_cfg;
          idx_d = idle_idx;
        end else begin
          idx_d = nxt_idx;
          cfg_d = mem_q[nxt_idx];
          loop_d = at_end ? loop_q - 8'd1 : loop_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        cfg_d = idle_cfg;
        idx_d = idle_idx;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fill_q <= '0;
      beat_q <= '0;
      end_q <= '0;
      loop_q <= '0;
      cfg_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      beat_q <= beat_d;
      end_q <= end_d;
      loop_q <= loop_d;
      cfg_q <= cfg_d;
      idx_q <= idx_d;
    end
  end
  assign config_all_o = cfg_q;
  assign ctx_idx_o = idx_q;
  assign busy_o = state_q == RUN;
  assign done_o = state_q == DONE;
  assign fill_o = fill_q;
endmodule

// File: tb/tb_fu_cfg_seq.sv
// tb_fu_cfg_seq: randomized self-checking bench against a slot-array playback model
module tb_fu_cfg_seq;
  logic clk = 0;
  logic rst_n, cfg_valid, cfg_ready, load_clr, start, halt, busy, done;
  logic [15:0] cfg_data;
  logic [2:0] last_ctx, ctx_idx;
  logic [7:0] loops;
  logic [63:0] config_all;
  logic [3:0] fill;
  logic [63:0] model_mem [8];
  int model_fill;
  int tests = 0;
  int fails = 0;
  fu_cfg_seq dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid_i(cfg_valid), .cfg_data_i(cfg_data),
    .cfg_ready_o(cfg_ready), .load_clr_i(load_clr), .start_i(start),
    .last_ctx_i(last_ctx), .loops_i(loops), .halt_i(halt),
    .config_all_o(config_all), .ctx_idx_o(ctx_idx), .busy_o(busy),
    .done_o(done), .fill_o(fill)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load_word(input logic [63:0] w);
    for (int b = 0; b < 4; b++) begin
      cfg_valid = 1;
      cfg_data = w[b*16 +: 16];
      #1;
      tests++;
      if (cfg_ready !== 1'b1) begin
        fails++;
        $display("FAIL load_ready: beat %0d ready=%b expected 1", b, cfg_ready);
      end
      step();
    end
    cfg_valid = 0;
    model_mem[model_fill] = w;
    model_fill++;
    tests++;
    if (fill !== 4'(model_fill)) begin
      fails++;
      $display("FAIL load_fill: fill=%0d expected %0d", fill, model_fill);
    end
  endtask
  task automatic partial(input int n);
    for (int b = 0; b < n; b++) begin
      cfg_valid = 1;
      cfg_data = 16'($urandom);
      step();
    end
    cfg_valid = 0;
  endtask
  task automatic clear();
    load_clr = 1;
    step();
    load_clr = 0;
    model_fill = 0;
  endtask
  task automatic play(input int last, input int nloops, input int halt_at);
    int e, total, slot, played;
    bit halted;
    logic [63:0] exp_cfg;
    logic [2:0] exp_idx;
    e = last < model_fill ? last : model_fill - 1;
    total = (e + 1) * (nloops + 1);
    last_ctx = 3'(last);
    loops = 8'(nloops);
    start = 1;
    step();
    start = 0;
    played = 0;
    halted = 0;
    for (int n = 0; n < total && !halted; n++) begin
      slot = n % (e + 1);
      tests++;
      if (busy !== 1'b1 || done !== 1'b0 || ctx_idx !== 3'(slot) || config_all !== model_mem[slot]) begin
        fails++;
        $display("FAIL run_cycle %0d: busy=%b done=%b idx=%0d cfg=%h expected busy=1 done=0 idx=%0d cfg=%h",
                 n, busy, done, ctx_idx, config_all, slot, model_mem[slot]);
      end
      played = slot;
      if (n == halt_at) begin
        halt = 1;
        step();
        halt = 0;
        halted = 1;
      end else step();
    end
`ifdef CFG_SEQ_HOLD_LAST_EN
    exp_cfg = model_mem[played];
    exp_idx = 3'(played);
`else
    exp_cfg = '0;
    exp_idx = '0;
`endif
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || config_all !== exp_cfg || ctx_idx !== exp_idx) begin
      fails++;
      $display("FAIL done_cycle: done=%b busy=%b cfg=%h idx=%0d expected done=1 busy=0 cfg=%h idx=%0d",
               done, busy, config_all, ctx_idx, exp_cfg, exp_idx);
    end
    step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || config_all !== exp_cfg || cfg_ready !== (model_fill < 8)) begin
      fails++;
      $display("FAIL after_done: done=%b busy=%b cfg=%h ready=%b expected done=0 busy=0 cfg=%h ready=%b",
               done, busy, config_all, cfg_ready, exp_cfg, model_fill < 8);
    end
  endtask
  task automatic test_reset();
    tests++;
    if (config_all !== 64'h0 || ctx_idx !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || fill !== 4'd0 || cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: cfg=%h idx=%0d busy=%b done=%b fill=%0d ready=%b expected 0 0 0 0 0 1",
               config_all, ctx_idx, busy, done, fill, cfg_ready);
    end
  endtask
  task automatic test_basic();
    load_word(64'h1);
    load_word(64'h2);
    load_word(64'h3);
    play(2, 0, -1);
  endtask
  task automatic test_loops();
    play(2, 2, -1);
  endtask
  task automatic test_halt();
    play(2, 0, 1);
  endtask
  task automatic test_full();
    clear();
    for (int i = 0; i < 8; i++) load_word({$urandom, $urandom});
    tests++;
    if (cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_ready: ready=%b expected 0", cfg_ready);
    end
    cfg_valid = 1;
    cfg_data = 16'($urandom);
    step();
    cfg_valid = 0;
    tests++;
    if (fill !== 4'd8 || cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_extra_beat: fill=%0d ready=%b expected 8 0", fill, cfg_ready);
    end
    load_clr = 1;
    #1;
    tests++;
    if (cfg_ready !== 1'b0) begin
      fails++;
      $display("FAIL clr_ready: ready=%b expected 0 during load_clr", cfg_ready);
    end
    step();
    load_clr = 0;
    model_fill = 0;
    #1;
    tests++;
    if (fill !== 4'd0 || cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL clr_restore: fill=%0d ready=%b expected 0 1", fill, cfg_ready);
    end
  endtask
  task automatic test_clamp();
    clear();
    load_word({$urandom, $urandom});
    load_word({$urandom, $urandom});
    play(7, 1, -1);
    clear();
    start = 1;
    step();
    start = 0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL empty_start: busy=%b done=%b expected 0 0", busy, done);
    end
    step();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL empty_start_next: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask
  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n;
      clear();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) load_word({$urandom, $urandom});
      if (n < 8) partial($urandom_range(0, 3));
      play($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1) ? -1 : $urandom_range(0, 12));
    end
  endtask
  task automatic test_reset_midrun();
    logic [63:0] w;
    clear();
    for (int i = 0; i < 3; i++) load_word({$urandom, $urandom});
    partial(2);
    last_ctx = 3'd2;
    loops = 8'd5;
    start = 1;
    step();
    start = 0;
    step();
    rst_n = 0;
    #1;
    tests++;
    if (config_all !== 64'h0 || ctx_idx !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || fill !== 4'd0) begin
      fails++;
      $display("FAIL async_reset: cfg=%h idx=%0d busy=%b done=%b fill=%0d expected all 0",
               config_all, ctx_idx, busy, done, fill);
    end
    @(negedge clk);
    rst_n = 1;
    step();
    model_fill = 0;
    partial(2);
    rst_n = 0;
    #1;
    @(negedge clk);
    rst_n = 1;
    step();
    w = {$urandom, $urandom};
    load_word(w);
    play(0, 0, -1);
  endtask
  initial begin
    rst_n = 0;
    cfg_valid = 0;
    cfg_data = 0;
    load_clr = 0;
    start = 0;
    halt = 0;
    last_ctx = 0;
    loops = 0;
    model_fill = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    step();
    test_reset();
    test_basic();
    test_loops();
    test_halt();
    test_full();
    test_clamp();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fu_cfg_seq.md
# fu_cfg_seq

Configuration sequencer that drives the `config_all` bus of a PE functional-unit cluster. It accepts configuration words over a narrow valid/ready load stream and stores them in a small context register file. On `start_i` it replays the stored contexts one per clock, optionally looping, so the FU cluster is reconfigured every cycle without host involvement. It sits between the PE control port and the FU cluster's configuration input.

## Interface
- `CONFIG_ALL`, 64, width of one context word (equals the FU cluster config width)
- `IN_WIDTH`, 16, load-stream beat width; `CONFIG_ALL` is a multiple of `IN_WIDTH`
- `NUM_CTX`, 8, number of context slots (power of two)
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `cfg_valid_i`  in  1  load beat valid
- `cfg_data_i`  in  IN_WIDTH  load beat data
- `cfg_ready_o`  out  1  load beat accepted when `cfg_valid_i & cfg_ready_o`
- `load_clr_i`  in  1  reset load pointer and fill count (contents not erased)
- `start_i`  in  1  begin playback
- `last_ctx_i`  in  $clog2(NUM_CTX)  index of last context to play, sampled at start
- `loops_i`  in  8  iterations minus one, sampled at start
- `halt_i`  in  1  abort playback
- `config_all_o`  out  CONFIG_ALL  registered context driven to the FU cluster
- `ctx_idx_o`  out  $clog2(NUM_CTX)  index of the context currently on `config_all_o`
- `busy_o`  out  1  high in RUN
- `done_o`  out  1  one-cycle pulse at end of playback or halt
- `fill_o`  out  $clog2(NUM_CTX)+1  number of complete words stored

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- Load happens only in IDLE. `BEATS = CONFIG_ALL/IN_WIDTH`. Beats arrive LSB-first into slot `fill_o`. The word becomes complete, and `fill_o` increments, on the final beat.
- `cfg_ready_o = (state==IDLE) & (fill_o < NUM_CTX) & !load_clr_i`.
- `load_clr_i` zeroes `fill_o` and the beat counter; it has priority over a same-cycle beat.
- IDLE → RUN on `start_i` when `fill_o != 0`. When `fill_o == 0`, `start_i` is ignored: no busy, no done.
- At start, the end index latches `min(last_ctx_i, fill_o-1)` and the remaining-loop counter latches `loops_i`. A partially loaded word is discarded: the beat counter is cleared at start.
- In RUN, slot `ctx_idx_o` advances each cycle. After the end index it wraps to 0 and the loop counter decrements. When the end index is presented with the loop counter at 0, the next state is DONE.
- `halt_i` in RUN → DONE next cycle; the current context is not advanced.
- DONE lasts one cycle: `done_o=1`, then IDLE. `start_i` in DONE is ignored.
- `start_i` and `halt_i` in IDLE in the same cycle: `start_i` wins; `halt_i` has effect only in RUN.

## Timing
- Reset values: `config_all_o=0`, `ctx_idx_o=0`, `busy_o=0`, `done_o=0`, `cfg_ready_o` goes to 1 after reset deassert, `fill_o=0`; slot contents are undefined until loaded.
- Latency: `start_i` at cycle T → `busy_o=1` and `config_all_o=ctx[0]` at T+1. Slot k is on the bus at T+1+k of the first iteration.
- Total RUN cycles = (end+1)×(loops+1). `done_o` is high in the cycle after the last RUN cycle, and `busy_o` is low in that cycle.
- One load beat is accepted per cycle with no bubbles. A word written at cycle T is playable from T+1.
- Asynchronous reset mid-RUN or mid-load: immediate return to reset values; a partially loaded word is lost.

## Configuration
- `CFG_SEQ_HOLD_LAST_EN` defined: in DONE and IDLE, `config_all_o` holds the last context played, and `ctx_idx_o` holds its index.
- Not defined: in DONE and IDLE, `config_all_o=0`, which is the FU NOP encoding, and `ctx_idx_o=0`.
- Reset value is 0 in both builds.

## Test plan
- Load 3 words (12 beats) of 0x…0001/0002/0003, then `start_i` with `last_ctx_i=2`, `loops_i=0` → bus shows 1,2,3 at T+1..T+3; `done_o` at T+4; `fill_o=3`.
- Same contents with `loops_i=2` → sequence 1,2,3 repeated 3×, 9 busy cycles, `done_o` at T+10.
- Load NUM_CTX words → `cfg_ready_o=0` after the 32nd beat; an extra beat with valid held is not accepted; `load_clr_i` then restores ready and `fill_o=0`.
- `last_ctx_i=7` with `fill_o=2` → plays slots 0,1 only; `start_i` with `fill_o=0` → no busy, no done.
- `halt_i` on the 2nd RUN cycle → `done_o` next cycle. The bus shows 0 without the macro, or holds slot 1 with `CFG_SEQ_HOLD_LAST_EN`.
- `rst_n` asserted mid-RUN after 2 beats of a pending load → all outputs 0 immediately, `fill_o=0`, subsequent load starts at slot 0, beat 0.
